// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register for the 5-stage MIPS pipeline.
// Latches the ALU result, store data and control bits, and owns the HI/LO
// registers, the retired-instruction counter and the sticky halt flag.
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_result1,
    input  logic [DATA_W-1:0] ex_alu_result2,
    input  logic [DATA_W-1:0] ex_rt_data,
    input  logic [4:0]        ex_rd_addr,
    input  logic [DATA_W-1:0] ex_pc,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_hilo_write,
    input  logic              ex_sel_hi,
    input  logic              ex_sel_lo,
    input  logic              ex_halt,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_result,
    output logic [DATA_W-1:0] mem_rt_data,
    output logic [4:0]        mem_rd_addr,
    output logic [DATA_W-1:0] mem_pc,
    output logic              mem_reg_write,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic              mem_halt,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    output logic [CNT_W-1:0]  retire_count
);

    logic [DATA_W-1:0] hi_q, lo_q;
    logic [DATA_W-1:0] sel_result;
    logic              capture;

    // A real instruction enters MEM only when nothing blocks it and we have not halted.
    assign capture = ~stall & ~flush & ex_valid & ~mem_halt;

    // mfhi/mflo read the HI/LO values from before this edge; HI wins if both selects are set.
    always_comb begin
        sel_result = ex_alu_result1;
        if (ex_sel_hi)
            sel_result = hi_q;
        else if (ex_sel_lo)
            sel_result = lo_q;
    end

    // Stage register: reset > flush > stall > capture; anything else loads a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_valid     <= 1'b0;
            mem_result    <= '0;
            mem_rt_data   <= '0;
            mem_rd_addr   <= '0;
            mem_pc        <= '0;
            mem_reg_write <= 1'b0;
            mem_mem_read  <= 1'b0;
            mem_mem_write <= 1'b0;
        end else if (capture) begin
            mem_valid     <= 1'b1;
            mem_result    <= sel_result;
            mem_rt_data   <= ex_rt_data;
            mem_rd_addr   <= ex_rd_addr;
            mem_pc        <= ex_pc;
            mem_reg_write <= ex_reg_write;
            mem_mem_read  <= ex_mem_read;
            mem_mem_write <= ex_mem_write;
        end else if (flush || !stall) begin
            mem_valid     <= 1'b0;
            mem_result    <= '0;
            mem_rt_data   <= '0;
            mem_rd_addr   <= '0;
            mem_pc        <= '0;
            mem_reg_write <= 1'b0;
            mem_mem_read  <= 1'b0;
            mem_mem_write <= 1'b0;
        end
    end

    // Architectural state only advances on a capture, so flush/stall/halt all freeze it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q         <= '0;
            lo_q         <= '0;
            retire_count <= '0;
            mem_halt     <= 1'b0;
        end else if (capture) begin
            if (ex_hilo_write) begin
                hi_q <= ex_alu_result2;
                lo_q <= ex_alu_result1;
            end
            if (retire_count != {CNT_W{1'b1}})
                retire_count <= retire_count + 1'b1;
            if (ex_halt)
                mem_halt <= 1'b1;
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus random traffic,
// each edge compared against a behavioural model of the stage rules.
module tb_ex_mem_stage;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n, stall, flush, ex_valid;
    logic [DW-1:0] ex_alu_result1, ex_alu_result2, ex_rt_data, ex_pc;
    logic [4:0]    ex_rd_addr;
    logic          ex_reg_write, ex_mem_read, ex_mem_write;
    logic          ex_hilo_write, ex_sel_hi, ex_sel_lo, ex_halt;
    logic          mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_halt;
    logic [DW-1:0] mem_result, mem_rt_data, mem_pc, hi_out, lo_out;
    logic [4:0]    mem_rd_addr;
    logic [CW-1:0] retire_count;

    int checks = 0;
    int failures = 0;

    // model state
    logic          m_valid, m_rw, m_mr, m_mw, m_halt;
    logic [DW-1:0] m_result, m_rt, m_pc, m_hi, m_lo;
    logic [4:0]    m_rd;
    int            m_cnt;

    always #5 clk = ~clk;

    ex_mem_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .ex_valid(ex_valid),
        .ex_alu_result1(ex_alu_result1), .ex_alu_result2(ex_alu_result2),
        .ex_rt_data(ex_rt_data), .ex_rd_addr(ex_rd_addr), .ex_pc(ex_pc),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_hilo_write(ex_hilo_write), .ex_sel_hi(ex_sel_hi), .ex_sel_lo(ex_sel_lo),
        .ex_halt(ex_halt), .mem_valid(mem_valid), .mem_result(mem_result),
        .mem_rt_data(mem_rt_data), .mem_rd_addr(mem_rd_addr), .mem_pc(mem_pc),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_halt(mem_halt), .hi_out(hi_out),
        .lo_out(lo_out), .retire_count(retire_count)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bubble_model();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_rd = 0;
        m_result = 0; m_rt = 0; m_pc = 0;
    endtask

    // Advance the model by one edge using the inputs now on the pins, clock the DUT, compare.
    task automatic tick();
        logic [DW-1:0] old_hi, old_lo;
        old_hi = m_hi; old_lo = m_lo;
        if (!rst_n) begin
            bubble_model();
            m_hi = 0; m_lo = 0; m_cnt = 0; m_halt = 0;
        end else if (flush) begin
            bubble_model();
        end else if (stall) begin
            // everything holds
        end else if (ex_valid && !m_halt) begin
            m_valid = 1; m_rw = ex_reg_write; m_mr = ex_mem_read; m_mw = ex_mem_write;
            m_rd = ex_rd_addr; m_rt = ex_rt_data; m_pc = ex_pc;
            m_result = ex_sel_hi ? old_hi : (ex_sel_lo ? old_lo : ex_alu_result1);
            if (ex_hilo_write) begin
                m_hi = ex_alu_result2; m_lo = ex_alu_result1;
            end
            if (m_cnt < (1 << CW) - 1) m_cnt++;
            if (ex_halt) m_halt = 1;
        end else begin
            bubble_model();
        end
        @(posedge clk);
        #1;
        chk("mem_valid", 32'(mem_valid), 32'(m_valid));
        chk("mem_result", mem_result, m_result);
        chk("mem_rt_data", mem_rt_data, m_rt);
        chk("mem_rd_addr", 32'(mem_rd_addr), 32'(m_rd));
        chk("mem_pc", mem_pc, m_pc);
        chk("mem_ctrl", {29'b0, mem_reg_write, mem_mem_read, mem_mem_write}, {29'b0, m_rw, m_mr, m_mw});
        chk("mem_halt", 32'(mem_halt), 32'(m_halt));
        chk("hi_out", hi_out, m_hi);
        chk("lo_out", lo_out, m_lo);
        chk("retire_count", 32'(retire_count), 32'(m_cnt));
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; ex_valid = 0;
        ex_alu_result1 = 0; ex_alu_result2 = 0; ex_rt_data = 0; ex_pc = 0; ex_rd_addr = 0;
        ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0;
        ex_hilo_write = 0; ex_sel_hi = 0; ex_sel_lo = 0; ex_halt = 0;
    endtask

    task automatic rand_payload();
        ex_alu_result1 = $urandom(); ex_alu_result2 = $urandom();
        ex_rt_data = $urandom(); ex_pc = $urandom(); ex_rd_addr = 5'($urandom());
        ex_reg_write = 1'($urandom_range(0, 1)); ex_mem_read = 1'($urandom_range(0, 1));
        ex_mem_write = 1'($urandom_range(0, 1)); ex_hilo_write = 1'($urandom_range(0, 1));
        ex_sel_hi = 1'($urandom_range(0, 1)); ex_sel_lo = 1'($urandom_range(0, 1));
    endtask

    initial begin
        m_hi = 'x; m_lo = 'x; m_cnt = 0; m_halt = 0;
        // Reset with every input forced high, including stall.
        rst_n = 0;
        stall = 1; flush = 1; ex_valid = 1;
        ex_alu_result1 = '1; ex_alu_result2 = '1; ex_rt_data = '1; ex_pc = '1; ex_rd_addr = '1;
        ex_reg_write = 1; ex_mem_read = 1; ex_mem_write = 1;
        ex_hilo_write = 1; ex_sel_hi = 1; ex_sel_lo = 1; ex_halt = 1;
        tick(); tick();
        chk("reset_all_zero", {mem_result | hi_out | lo_out | mem_pc}, 32'h0);

        // Capture then stall with changing inputs.
        rst_n = 1; clear_inputs();
        ex_valid = 1; ex_alu_result1 = 32'h5; ex_rd_addr = 5'd8; ex_reg_write = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            stall = 1; ex_valid = 1; rand_payload();
            tick();
            chk("stall_hold_result", mem_result, 32'h5);
            chk("stall_hold_rd", 32'(mem_rd_addr), 32'd8);
            chk("stall_hold_count", 32'(retire_count), 32'd1);
        end

        // multu, then mfhi, then mflo.
        clear_inputs(); ex_valid = 1;
        ex_alu_result2 = 32'h1; ex_alu_result1 = 32'hFFFF_FFFE; ex_hilo_write = 1;
        tick();
        chk("multu_hi", hi_out, 32'h1);
        chk("multu_lo", lo_out, 32'hFFFF_FFFE);
        clear_inputs(); ex_valid = 1; ex_sel_hi = 1; ex_alu_result1 = 32'hDEAD_BEEF;
        tick();
        chk("mfhi_result", mem_result, 32'h1);
        clear_inputs(); ex_valid = 1; ex_sel_lo = 1; ex_alu_result1 = 32'h1234_5678;
        tick();
        chk("mflo_result", mem_result, 32'hFFFF_FFFE);

        // Flush during stall while a divu is in EX.
        clear_inputs(); flush = 1; stall = 1; ex_valid = 1; rand_payload(); ex_hilo_write = 1;
        tick();
        chk("flush_valid", 32'(mem_valid), 32'd0);
        chk("flush_hi", hi_out, 32'h1);
        chk("flush_count", 32'(retire_count), 32'd4);

        // Random traffic, no halts.
        for (int i = 0; i < 300; i++) begin
            clear_inputs();
            rand_payload();
            ex_valid = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 7) == 0);
            tick();
        end

        // Halt, then valid instructions that must be dropped.
        rst_n = 0; clear_inputs(); tick();
        rst_n = 1;
        for (int i = 0; i < 2; i++) begin clear_inputs(); ex_valid = 1; rand_payload(); tick(); end
        clear_inputs(); ex_valid = 1; ex_halt = 1; rand_payload(); tick();
        chk("halt_set", 32'(mem_halt), 32'd1);
        chk("halt_captured", 32'(mem_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            clear_inputs(); ex_valid = 1; rand_payload(); tick();
            chk("halt_bubble", 32'(mem_valid), 32'd0);
        end
        chk("halt_count", 32'(retire_count), 32'd3);
        rst_n = 0; clear_inputs(); tick();
        chk("halt_cleared", 32'(mem_halt), 32'd0);

        // Counter saturation.
        rst_n = 1;
        for (int i = 0; i < 20; i++) begin clear_inputs(); ex_valid = 1; rand_payload(); tick(); end
        chk("count_saturate", 32'(retire_count), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
